sfx_player: RTL and testbench

- Sound-effect sequencer that drives the board `audio` pin.
- It consumes the game-state interface that the game controller publishes (`status`, `score`) plus the raw `up` button.
- It detects game events and plays short square-wave note sequences from an internal ROM.
- It is a sibling consumer to the display path and replaces the constant `audio=0` tie-off in the top level.

---
 rtl/sfx_player_pkg.sv | 49 ++++
 rtl/sfx_player_rom.sv | 44 ++++
 rtl/sfx_player.sv | 223 ++++++++++++++++++++++
 tb/tb_sfx_player.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/sfx_player_pkg.sv
// Shared definitions for the sound-effect sequencer: status codes, effect ids,
// ROM entry layout, FSM state encoding and the effect priority ranking.
package sfx_player_pkg;

  // Game status codes published by the game controller (11 behaves as READY)
  localparam logic [1:0] ST_READY = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_OVER  = 2'b10;

  // Sound-effect identifiers as seen on sfx_id
  localparam logic [2:0] SFX_NONE  = 3'd0;
  localparam logic [2:0] SFX_START = 3'd1;
  localparam logic [2:0] SFX_SCORE = 3'd2;
  localparam logic [2:0] SFX_FLAP  = 3'd3;
  localparam logic [2:0] SFX_CRASH = 3'd4;

  // ROM entry layout: {last, hp_us, dur_ms}
  localparam int HP_W    = 12;
  localparam int DUR_W   = 9;
  localparam int ENTRY_W = 1 + HP_W + DUR_W;

  typedef struct packed {
    logic             last;
    logic [HP_W-1:0]  hp;
    logic [DUR_W-1:0] dur;
  } rom_entry_t;

  // Sequencer states
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_PLAY = 2'b10
  } state_t;

  // Rank of an effect; a higher rank may interrupt a lower one.
  // CRASH > START > SCORE > FLAP > nothing playing.
  function automatic logic [2:0] sfx_prio(input logic [2:0] id);
    logic [2:0] rank;
    case (id)
      SFX_CRASH: rank = 3'd4;
      SFX_START: rank = 3'd3;
      SFX_SCORE: rank = 3'd2;
      SFX_FLAP:  rank = 3'd1;
      default:   rank = 3'd0;
    endcase
    return rank;
  endfunction

endpackage

// File: rtl/sfx_player_rom.sv
// Note table for all sound effects. Four effects with up to four notes each,
// addressed by {id-1, note index}. Empty slots are a 1 ms terminating rest.
module sfx_player_rom
  import sfx_player_pkg::*;
(
  input  logic [2:0]         id_i,
  input  logic [1:0]         idx_i,
  output logic [ENTRY_W-1:0] entry_o
);

  logic [2:0] id_m1_s;
  logic [3:0] addr_s;

  function automatic logic [ENTRY_W-1:0] mk(input logic last,
                                            input logic [HP_W-1:0] hp,
                                            input logic [DUR_W-1:0] dur);
    return {last, hp, dur};
  endfunction

  assign id_m1_s = id_i - 3'd1;
  assign addr_s  = {id_m1_s[1:0], idx_i};

  // Combinational note lookup
  always_comb begin
    entry_o = mk(1'b1, 12'd0, 9'd1);
    case (addr_s)
      // START: rising three-note jingle
      4'd0:    entry_o = mk(1'b0, 12'd956,  9'd60);
      4'd1:    entry_o = mk(1'b0, 12'd759,  9'd60);
      4'd2:    entry_o = mk(1'b1, 12'd638,  9'd120);
      // SCORE: two-note chirp
      4'd4:    entry_o = mk(1'b0, 12'd506,  9'd40);
      4'd5:    entry_o = mk(1'b1, 12'd379,  9'd120);
      // FLAP: single short blip
      4'd8:    entry_o = mk(1'b1, 12'd568,  9'd30);
      // CRASH: low tone, pause, lower tone
      4'd12:   entry_o = mk(1'b0, 12'd2551, 9'd100);
      4'd13:   entry_o = mk(1'b0, 12'd0,    9'd50);
      4'd14:   entry_o = mk(1'b1, 12'd3817, 9'd300);
      default: entry_o = mk(1'b1, 12'd0,    9'd1);
    endcase
  end

endmodule

// File: rtl/sfx_player.sv
// Sound-effect sequencer: watches game status, score and the flap button,
// picks the highest-priority event and plays its note sequence as a square
// wave on the audio pin. mute only gates the pin; sequencing continues.
module sfx_player
  import sfx_player_pkg::*;
#(
  parameter int TICK_DIV  = 100000,
  parameter int TONE_UNIT = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  status,
  input  logic [15:0] score,
  input  logic        up,
  input  logic        mute,
  output logic        audio,
  output logic        busy,
  output logic [2:0]  sfx_id
);

  // Half-period counter must reach 4095*TONE_UNIT; keep at least 22 bits.
  localparam int HPC_RAW = $clog2(4095 * TONE_UNIT + 1);
  localparam int HPC_W   = (HPC_RAW > 22) ? HPC_RAW : 22;
  localparam int TCK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TCK_W-1:0] TICK_LAST = TCK_W'(TICK_DIV - 1);
  localparam logic [HPC_W-1:0] TONE_MUL  = HPC_W'(TONE_UNIT);

  // Event detection state
  logic [1:0]  prev_status_q;
  logic [15:0] prev_score_q;
  logic        prev_up_q;
  logic        armed_q;
  logic [2:0]  evt_q;

  // Sequencer state
  state_t            state_q, state_d;
  logic [2:0]        sfx_id_q, sfx_id_d;
  logic [1:0]        idx_q, idx_d;
  logic              busy_q, busy_d;
  logic              tone_q, tone_d;
  logic              audio_q;
  logic              note_last_q, note_last_d;
  logic [HP_W-1:0]   note_hp_q, note_hp_d;
  logic [DUR_W-1:0]  note_dur_q, note_dur_d;
  logic [HPC_W-1:0]  hp_cnt_q, hp_cnt_d;
  logic [TCK_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic [DUR_W-1:0]  dur_cnt_q, dur_cnt_d;

  // Combinational helpers
  logic [1:0]         status_n_s;
  logic               start_s, crash_s, score_s, flap_s;
  logic [2:0]         evt_id_s;
  logic               preempt_s;
  logic [ENTRY_W-1:0] rom_raw_s;
  rom_entry_t         rom_s;
  logic [HPC_W-1:0]   hp_lim_s;
  logic               tick_s;
  logic               note_end_s;

  sfx_player_rom u_rom (
    .id_i    (sfx_id_q),
    .idx_i   (idx_q),
    .entry_o (rom_raw_s)
  );

  assign rom_s = rom_entry_t'(rom_raw_s);

  // Classify the current inputs against last cycle's snapshot
  always_comb begin
    status_n_s = (status == 2'b11) ? ST_READY : status;
    start_s = armed_q && (prev_status_q == ST_READY) && (status_n_s == ST_RUN);
    crash_s = armed_q && (prev_status_q == ST_RUN) && (status_n_s == ST_OVER);
    score_s = armed_q && (status_n_s == ST_RUN) && (score == prev_score_q + 16'd1);
    flap_s  = armed_q && (status_n_s == ST_RUN) && up && !prev_up_q;
    if (crash_s) begin
      evt_id_s = SFX_CRASH;
    end else if (start_s) begin
      evt_id_s = SFX_START;
    end else if (score_s) begin
      evt_id_s = SFX_SCORE;
    end else if (flap_s) begin
      evt_id_s = SFX_FLAP;
    end else begin
      evt_id_s = SFX_NONE;
    end
  end

  // Snapshot inputs every cycle and register the winning event
  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_status_q <= ST_READY;
      prev_score_q  <= 16'd0;
      prev_up_q     <= 1'b0;
      armed_q       <= 1'b0;
      evt_q         <= SFX_NONE;
    end else begin
      prev_status_q <= status_n_s;
      prev_score_q  <= score;
      prev_up_q     <= up;
      armed_q       <= 1'b1;
      evt_q         <= evt_id_s;
    end
  end

  assign preempt_s  = (evt_q != SFX_NONE) && (sfx_prio(evt_q) >= sfx_prio(sfx_id_q));
  assign hp_lim_s   = HPC_W'(note_hp_q) * TONE_MUL - HPC_W'(1);
  assign tick_s     = (tick_cnt_q == TICK_LAST);
  assign note_end_s = tick_s && (dur_cnt_q == note_dur_q - 9'd1);

  // Next-state logic: preemption first, then the per-state behaviour
  always_comb begin
    state_d     = state_q;
    sfx_id_d    = sfx_id_q;
    idx_d       = idx_q;
    busy_d      = busy_q;
    tone_d      = tone_q;
    note_last_d = note_last_q;
    note_hp_d   = note_hp_q;
    note_dur_d  = note_dur_q;
    hp_cnt_d    = hp_cnt_q;
    tick_cnt_d  = tick_cnt_q;
    dur_cnt_d   = dur_cnt_q;
    if (preempt_s) begin
      state_d  = S_LOAD;
      sfx_id_d = evt_q;
      idx_d    = 2'd0;
      busy_d   = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          sfx_id_d   = SFX_NONE;
          busy_d     = 1'b0;
          tone_d     = 1'b0;
          idx_d      = 2'd0;
          hp_cnt_d   = '0;
          tick_cnt_d = '0;
          dur_cnt_d  = '0;
        end
        S_LOAD: begin
          note_last_d = rom_s.last;
          note_hp_d   = rom_s.hp;
          note_dur_d  = rom_s.dur;
          hp_cnt_d    = '0;
          tick_cnt_d  = '0;
          dur_cnt_d   = '0;
          tone_d      = 1'b0;
          state_d     = S_PLAY;
        end
        S_PLAY: begin
          if (note_end_s) begin
            if (note_last_q) begin
              state_d  = S_IDLE;
              sfx_id_d = SFX_NONE;
              busy_d   = 1'b0;
              tone_d   = 1'b0;
            end else begin
              idx_d   = idx_q + 2'd1;
              state_d = S_LOAD;
            end
          end else begin
            if (tick_s) begin
              tick_cnt_d = '0;
              dur_cnt_d  = dur_cnt_q + 9'd1;
            end else begin
              tick_cnt_d = tick_cnt_q + TCK_W'(1);
            end
            if (note_hp_q == 12'd0) begin
              tone_d   = 1'b0;
              hp_cnt_d = '0;
            end else if (hp_cnt_q == hp_lim_s) begin
              tone_d   = ~tone_q;
              hp_cnt_d = '0;
            end else begin
              hp_cnt_d = hp_cnt_q + HPC_W'(1);
            end
          end
        end
        default: begin
          state_d  = S_IDLE;
          sfx_id_d = SFX_NONE;
          busy_d   = 1'b0;
          tone_d   = 1'b0;
        end
      endcase
    end
  end

  // Sequencer registers and the gated audio output
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      sfx_id_q    <= SFX_NONE;
      idx_q       <= 2'd0;
      busy_q      <= 1'b0;
      tone_q      <= 1'b0;
      audio_q     <= 1'b0;
      note_last_q <= 1'b0;
      note_hp_q   <= 12'd0;
      note_dur_q  <= 9'd0;
      hp_cnt_q    <= '0;
      tick_cnt_q  <= '0;
      dur_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      sfx_id_q    <= sfx_id_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      tone_q      <= tone_d;
      audio_q     <= tone_d & ~mute;
      note_last_q <= note_last_d;
      note_hp_q   <= note_hp_d;
      note_dur_q  <= note_dur_d;
      hp_cnt_q    <= hp_cnt_d;
      tick_cnt_q  <= tick_cnt_d;
      dur_cnt_q   <= dur_cnt_d;
    end
  end

  assign audio  = audio_q;
  assign busy   = busy_q;
  assign sfx_id = sfx_id_q;

endmodule

// File: tb/tb_sfx_player.sv
// Bench for sfx_player with a short ms tick (50 clocks) and 1-clock tone unit.
// Every sfx_id change is checked against a queue of expected ids pushed when
// the triggering stimulus is driven; timing is checked as cycle offsets.
module tb_sfx_player;

  localparam int TD = 50;
  localparam int TU = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  status = 2'b01;
  logic [15:0] score = 16'd0;
  logic        up = 1'b0;
  logic        mute = 1'b0;
  logic        audio;
  logic        busy;
  logic [2:0]  sfx_id;

  int n_pass  = 0;
  int n_total = 0;
  int el      = 0;

  logic [2:0] exp_q[$];
  logic [2:0] last_id = 3'd0;
  logic [2:0] sb_e;

  typedef struct {
    logic [1:0]  st0;
    logic [15:0] sc0;
    logic        u0;
    logic [1:0]  st1;
    logic [15:0] sc1;
    logic        u1;
    logic [2:0]  exp_id;
  } vec_t;

  vec_t vecs[14];

  always #5 clk = ~clk;

  sfx_player #(.TICK_DIV(TD), .TONE_UNIT(TU)) dut (
    .clk    (clk),
    .rst    (rst),
    .status (status),
    .score  (score),
    .up     (up),
    .mute   (mute),
    .audio  (audio),
    .busy   (busy),
    .sfx_id (sfx_id)
  );

  function automatic void chk(input string name, input int act, input int expv);
    n_total++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, expv);
  endfunction

  // Scoreboard: each change of sfx_id must match the next expected id
  always @(negedge clk) begin
    if (sfx_id !== last_id) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_id", int'(sfx_id), int'(last_id));
      end else begin
        sb_e = exp_q.pop_front();
        chk("sb_id", int'(sfx_id), int'(sb_e));
      end
      chk("sb_busy", int'(busy), int'(sfx_id != 3'd0));
      last_id = sfx_id;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      el++;
    end
  endtask

  // Wait for audio (sel=0) or busy (sel=1) to reach val; check the offset
  task automatic wait_sig(input int sel, input logic val, input int exp_el,
                          input string name);
    int n;
    logic v;
    n = 0;
    do begin
      @(negedge clk);
      el++;
      n++;
      v = (sel == 0) ? audio : busy;
    end while (v !== val && n < 20000);
    if (v !== val) chk({name, "_timeout"}, 0, 1);
    else chk(name, el, exp_el);
  endtask

  task automatic do_reset(input logic [1:0] st, input logic [15:0] sc, input logic u);
    rst = 1'b0; status = st; score = sc; up = u; mute = 1'b0;
    step(3);
    rst = 1'b1;
    step(3);
  endtask

  initial begin
    vecs[0]  = '{2'b00, 16'd0,     1'b0, 2'b01, 16'd0, 1'b0, 3'd1}; // START
    vecs[1]  = '{2'b01, 16'd5,     1'b0, 2'b10, 16'd5, 1'b0, 3'd4}; // CRASH
    vecs[2]  = '{2'b01, 16'd5,     1'b0, 2'b01, 16'd6, 1'b0, 3'd2}; // SCORE +1
    vecs[3]  = '{2'b01, 16'd5,     1'b0, 2'b01, 16'd5, 1'b1, 3'd3}; // FLAP
    vecs[4]  = '{2'b01, 16'd7,     1'b0, 2'b01, 16'd0, 1'b0, 3'd0}; // clear
    vecs[5]  = '{2'b01, 16'd3,     1'b0, 2'b01, 16'd5, 1'b0, 3'd0}; // jump
    vecs[6]  = '{2'b01, 16'd9,     1'b0, 2'b01, 16'd8, 1'b0, 3'd0}; // decrease
    vecs[7]  = '{2'b00, 16'd5,     1'b0, 2'b00, 16'd5, 1'b1, 3'd0}; // flap in READY
    vecs[8]  = '{2'b00, 16'd5,     1'b0, 2'b00, 16'd6, 1'b0, 3'd0}; // score in READY
    vecs[9]  = '{2'b11, 16'd0,     1'b0, 2'b01, 16'd0, 1'b0, 3'd1}; // 11 acts as READY
    vecs[10] = '{2'b00, 16'd5,     1'b0, 2'b01, 16'd6, 1'b1, 3'd1}; // START wins
    vecs[11] = '{2'b01, 16'd65535, 1'b0, 2'b01, 16'd0, 1'b0, 3'd2}; // 16-bit wrap
    vecs[12] = '{2'b10, 16'd5,     1'b0, 2'b01, 16'd5, 1'b0, 3'd0}; // OVER->RUN
    vecs[13] = '{2'b01, 16'd5,     1'b0, 2'b01, 16'd6, 1'b1, 3'd2}; // SCORE beats FLAP

    // Reset held with RUN already present: arming must suppress START
    step(3);
    chk("rst_audio", int'(audio), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_id", int'(sfx_id), 0);
    rst = 1'b1;
    step(5);
    chk("arm_audio", int'(audio), 0);
    chk("arm_busy", int'(busy), 0);
    chk("arm_id", int'(sfx_id), 0);

    // Table of single events from a freshly armed state
    for (int i = 0; i < 14; i++) begin
      do_reset(vecs[i].st0, vecs[i].sc0, vecs[i].u0);
      status = vecs[i].st1; score = vecs[i].sc1; up = vecs[i].u1;
      if (vecs[i].exp_id != 3'd0) exp_q.push_back(vecs[i].exp_id);
      step(1);
      chk($sformatf("vec%0d_early", i), int'(sfx_id), 0);
      step(1);
      chk($sformatf("vec%0d_id", i), int'(sfx_id), int'(vecs[i].exp_id));
      chk($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].exp_id != 3'd0));
      if (vecs[i].exp_id != 3'd0) exp_q.push_back(3'd0);
    end

    // Full START jingle timing
    do_reset(2'b00, 16'd0, 1'b0);
    status = 2'b01;
    exp_q.push_back(3'd1);
    exp_q.push_back(3'd0);
    step(2);
    el = 0;
    chk("start_id", int'(sfx_id), 1);
    wait_sig(0, 1'b1, 957,   "start_n0_rise1");
    wait_sig(0, 1'b0, 1913,  "start_n0_fall1");
    wait_sig(0, 1'b1, 2869,  "start_n0_rise2");
    wait_sig(0, 1'b0, 3002,  "start_load1_clear");
    wait_sig(0, 1'b1, 3761,  "start_n1_rise1");
    wait_sig(0, 1'b0, 4520,  "start_n1_fall1");
    wait_sig(0, 1'b1, 5279,  "start_n1_rise2");
    wait_sig(0, 1'b0, 6003,  "start_load2_clear");
    wait_sig(0, 1'b1, 6641,  "start_n2_rise1");
    wait_sig(1, 1'b0, 12003, "start_busy_fall");

    // FLAP with up held high afterwards: no retrigger
    up = 1'b1;
    exp_q.push_back(3'd3);
    exp_q.push_back(3'd0);
    step(2);
    el = 0;
    chk("flap_id", int'(sfx_id), 3);
    wait_sig(0, 1'b1, 569,  "flap_rise1");
    wait_sig(0, 1'b0, 1137, "flap_fall1");
    wait_sig(1, 1'b0, 1501, "flap_busy_fall");
    step(200);
    chk("flap_no_retrigger", int'(sfx_id), 0);
    up = 1'b0;

    // SCORE preempts FLAP, then a FLAP during SCORE is dropped
    score = 16'd5;
    step(3);
    up = 1'b1;
    exp_q.push_back(3'd3);
    step(1);
    up = 1'b0;
    step(99);
    chk("flap2_id", int'(sfx_id), 3);
    score = 16'd6;
    exp_q.push_back(3'd2);
    step(2);
    el = 0;
    chk("score_id", int'(sfx_id), 2);
    chk("score_busy", int'(busy), 1);
    wait_sig(0, 1'b1, 507, "score_rise1");
    up = 1'b1;
    step(1);
    up = 1'b0;
    step(5);
    chk("flap_dropped", int'(sfx_id), 2);

    // CRASH preempts SCORE; rest note keeps audio low; mute gates the pin
    status = 2'b10;
    exp_q.push_back(3'd4);
    step(2);
    el = 0;
    chk("crash_id", int'(sfx_id), 4);
    wait_sig(0, 1'b1, 2552,  "crash_n0_rise1");
    wait_sig(0, 1'b0, 5002,  "crash_load_clear");
    wait_sig(0, 1'b1, 11320, "crash_after_rest");
    mute = 1'b1;
    step(2);
    chk("mute_audio", int'(audio), 0);
    chk("mute_busy", int'(busy), 1);
    step(50);
    chk("mute_id", int'(sfx_id), 4);

    // Reset in the middle of CRASH
    exp_q.push_back(3'd0);
    rst = 1'b0;
    step(1);
    chk("midrst_audio", int'(audio), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_id", int'(sfx_id), 0);
    rst = 1'b1;
    mute = 1'b0;
    step(5);
    chk("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
